// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the dot-product sequencer.
// The drain depth follows from the operand-read and PE latencies.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int SRAM_RD_LAT = 1;
  localparam int PE_LAT      = 1;
  localparam int DRAIN_DEPTH = SRAM_RD_LAT + PE_LAT;
  localparam int DRAIN_CNT_W = $clog2(DRAIN_DEPTH + 1);

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_ACC_W  = 16;

endpackage

// File: rtl/mult.sv
// Processing element: registered 8x8 multiply keeping only the low 8 bits
// of the product; the output holds while the enable is low.
module mult (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] acc_out
);

  logic [15:0] prod;
  logic [7:0]  acc_out_d;
  logic [7:0]  acc_out_q;

  always_comb begin
    prod      = a * b;
    acc_out_d = acc_out_q;
    if (en) begin
      acc_out_d = prod[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out_q <= 8'd0;
    end else begin
      acc_out_q <= acc_out_d;
    end
  end

  assign acc_out = acc_out_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams N operand pairs from two SRAMs into one PE,
// accumulates the PE products and returns the sum on a valid/ready port.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid, once raised, holds its payload stable until that edge.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] cmd_act_base,
  input  logic [ADDR_W-1:0] cmd_wgt_base,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  input  logic [7:0]        act_rd_data,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [7:0]        wgt_rd_data,
  output logic              pe_en,
  output logic [7:0]        pe_a,
  output logic [7:0]        pe_b,
  input  logic [7:0]        pe_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output state_e            dbg_state
);

  // The sum of 2^LEN_W-1 eight-bit products must fit without wrapping.
  if (ACC_W < LEN_W + 8) begin : g_acc_w_check
    $error("mac_seq_ctrl: ACC_W must be at least LEN_W+8");
  end

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [ADDR_W-1:0]      act_base_q, act_base_d;
  logic [ADDR_W-1:0]      wgt_base_q, wgt_base_d;
  logic [LEN_W-1:0]       i_q, i_d;
  logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
  logic                   pe_en_q, pe_en_d;
  logic                   acc_en_q, acc_en_d;
  logic [ACC_W-1:0]       acc_q, acc_d;

  logic cmd_accept;
  logic last_issue;
  logic drain_done;

  assign cmd_accept = (state_q == IDLE) && cmd_valid;
  assign last_issue = (i_q == len_q - LEN_W'(1));
  assign drain_done = (drain_q == DRAIN_CNT_W'(DRAIN_DEPTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = (cmd_len != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, latched command and the read -> PE -> accumulate delay pipes
  always_comb begin
    len_d      = len_q;
    act_base_d = act_base_q;
    wgt_base_d = wgt_base_q;
    i_d        = i_q;
    drain_d    = '0;
    pe_en_d    = (state_q == ISSUE);
    acc_en_d   = pe_en_q;
    acc_d      = acc_q;

    if (acc_en_q) begin
      acc_d = acc_q + ACC_W'(pe_out);
    end

    if (state_q == ISSUE) begin
      i_d = i_q + LEN_W'(1);
    end

    if (state_q == DRAIN) begin
      drain_d = drain_q + DRAIN_CNT_W'(1);
    end

    if (cmd_accept) begin
      len_d      = cmd_len;
      act_base_d = cmd_act_base;
      wgt_base_d = cmd_wgt_base;
      i_d        = '0;
      acc_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      act_base_q <= '0;
      wgt_base_q <= '0;
      i_q        <= '0;
      drain_q    <= '0;
      pe_en_q    <= 1'b0;
      acc_en_q   <= 1'b0;
      acc_q      <= '0;
    end else begin
      len_q      <= len_d;
      act_base_q <= act_base_d;
      wgt_base_q <= wgt_base_d;
      i_q        <= i_d;
      drain_q    <= drain_d;
      pe_en_q    <= pe_en_d;
      acc_en_q   <= acc_en_d;
      acc_q      <= acc_d;
    end
  end

  // Output logic
  always_comb begin
    cmd_ready   = 1'b0;
    act_rd_en   = 1'b0;
    wgt_rd_en   = 1'b0;
    act_rd_addr = '0;
    wgt_rd_addr = '0;
    res_valid   = 1'b0;
    res_data    = '0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      ISSUE: begin
        act_rd_en   = 1'b1;
        wgt_rd_en   = 1'b1;
        act_rd_addr = act_base_q + ADDR_W'(i_q);
        wgt_rd_addr = wgt_base_q + ADDR_W'(i_q);
      end
      DONE: begin
        res_valid = 1'b1;
        res_data  = acc_q;
      end
      default: begin
      end
    endcase
  end

  // Operands pass straight through, forced to zero between valid beats
  assign pe_en     = pe_en_q;
  assign pe_a      = pe_en_q ? act_rd_data : 8'd0;
  assign pe_b      = pe_en_q ? wgt_rd_data : 8'd0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a mult PE and two 1-cycle SRAM models;
// expected addresses, sums, latencies and PE beat counts go through queues.
module tb_mac_seq_ctrl;
  import mac_seq_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic [7:0]  cmd_act_base;
  logic [7:0]  cmd_wgt_base;
  logic        act_rd_en;
  logic [7:0]  act_rd_addr;
  logic [7:0]  act_rd_data;
  logic        wgt_rd_en;
  logic [7:0]  wgt_rd_addr;
  logic [7:0]  wgt_rd_data;
  logic        pe_en;
  logic [7:0]  pe_a;
  logic [7:0]  pe_b;
  logic [7:0]  pe_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;
  state_e      dbg_state;

  mac_seq_ctrl #(.ADDR_W(8), .LEN_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_act_base(cmd_act_base), .cmd_wgt_base(cmd_wgt_base),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .pe_en(pe_en), .pe_a(pe_a), .pe_b(pe_b), .pe_out(pe_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  mult u_pe (
    .clk(clk), .rst(rst), .en(pe_en), .a(pe_a), .b(pe_b), .acc_out(pe_out)
  );

  // Behavioural operand SRAMs, data one cycle after the strobe
  logic [7:0] act_mem [0:255];
  logic [7:0] wgt_mem [0:255];
  always @(posedge clk) begin
    if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
    if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr];
  end

  // Scoreboard
  logic [15:0] exp_q[$];
  logic [7:0]  exp_act_q[$];
  logic [7:0]  exp_wgt_q[$];
  int          exp_lat_q[$];
  int          exp_pe_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Output monitor
  int         acc_cyc = 0;
  int         pe_cnt = 0;
  bit         res_seen = 0;
  logic [7:0] last_act_addr = 8'd0;
  logic [7:0] last_wgt_addr = 8'd0;

  always @(negedge clk) begin
    if (rst) begin
      res_seen = 0;
      pe_cnt   = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        pe_cnt  = 0;
      end
      if (pe_en) begin
        pe_cnt++;
        check("pe_a", pe_a, act_mem[last_act_addr]);
        check("pe_b", pe_b, wgt_mem[last_wgt_addr]);
      end
      if (act_rd_en) begin
        last_act_addr = act_rd_addr;
        if (exp_act_q.size() == 0) check("act_rd_unexpected", 1, 0);
        else check("act_rd_addr", act_rd_addr, exp_act_q.pop_front());
      end
      if (wgt_rd_en) begin
        last_wgt_addr = wgt_rd_addr;
        if (exp_wgt_q.size() == 0) check("wgt_rd_unexpected", 1, 0);
        else check("wgt_rd_addr", wgt_rd_addr, exp_wgt_q.pop_front());
      end
      if (res_valid && !res_seen) begin
        res_seen = 1;
        if (exp_lat_q.size() == 0) check("res_unexpected", 1, 0);
        else begin
          check("res_latency", cyc - acc_cyc, exp_lat_q.pop_front());
          check("pe_en_count", pe_cnt, exp_pe_q.pop_front());
        end
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_data_unexpected", 1, 0);
        else check("res_data", res_data, exp_q.pop_front());
        res_seen = 0;
        done_cnt++;
      end
    end
  end

  // Driver tasks
  task automatic send_cmd(input logic [7:0] n, input logic [7:0] ab, input logic [7:0] wb,
                          output logic [15:0] exp_sum);
    logic [7:0]  aa;
    logic [7:0]  wa;
    logic [15:0] prod;
    bit          taken;
    exp_sum = 16'd0;
    for (int i = 0; i < int'(n); i++) begin
      aa = ab + 8'(i);
      wa = wb + 8'(i);
      exp_act_q.push_back(aa);
      exp_wgt_q.push_back(wa);
      prod = act_mem[aa] * wgt_mem[wa];
      exp_sum = exp_sum + {8'h00, prod[7:0]};
    end
    exp_q.push_back(exp_sum);
    exp_lat_q.push_back((n == 8'd0) ? 1 : int'(n) + 3);
    exp_pe_q.push_back(int'(n));
    cmd_len      = n;
    cmd_act_base = ab;
    cmd_wgt_base = wb;
    cmd_valid    = 1'b1;
    taken = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        taken = 1;
        break;
      end
    end
    check("cmd_accept", taken, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 60; k++) begin
      if (done_cnt >= target) break;
      @(posedge clk);
    end
    check("result_handshake", done_cnt >= target, 1);
    #1;
  endtask

  task automatic fill_const(input logic [7:0] av, input logic [7:0] wv);
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = av;
      wgt_mem[i] = wv;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] es;
    int          jobs;
    jobs = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_len = 8'd0;
    cmd_act_base = 8'd0;
    cmd_wgt_base = 8'd0;
    res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 8'(i);
      wgt_mem[i] = 8'(255 - i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_act_rd_en", act_rd_en, 0);
    check("rst_wgt_rd_en", wgt_rd_en, 0);
    check("rst_pe_en", pe_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_addr", {act_rd_addr, wgt_rd_addr, pe_a, pe_b}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic N=4 job: 1*5+2*6+3*7+4*8
    for (int i = 0; i < 4; i++) begin
      act_mem[8'h10 + i] = 8'(i + 1);
      wgt_mem[8'h20 + i] = 8'(i + 5);
    end
    send_cmd(8'd4, 8'h10, 8'h20, es);
    jobs++; wait_done(jobs);

    // Zero-length job
    send_cmd(8'd0, 8'h33, 8'h44, es);
    jobs++; wait_done(jobs);

    // Products truncating to 0 and to 1
    fill_const(8'd16, 8'd16);
    send_cmd(8'd3, 8'h05, 8'h80, es);
    jobs++; wait_done(jobs);
    fill_const(8'd255, 8'd255);
    send_cmd(8'd3, 8'h07, 8'h90, es);
    jobs++; wait_done(jobs);

    // Address wrap on the activation side, random data
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 8'($urandom_range(0, 255));
      wgt_mem[i] = 8'($urandom_range(0, 255));
    end
    send_cmd(8'd4, 8'hFE, 8'h30, es);
    jobs++; wait_done(jobs);
    send_cmd(8'($urandom_range(5, 20)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), es);
    jobs++; wait_done(jobs);

    // Result stall with a command offered meanwhile
    res_ready = 1'b0;
    send_cmd(8'd2, 8'hA0, 8'hB0, es);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("stall_res_valid_rise", res_valid, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_len = 8'd5;
    repeat (5) begin
      @(negedge clk);
      check("stall_res_valid", res_valid, 1);
      check("stall_res_data", res_data, es);
      check("stall_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    jobs++; wait_done(jobs);
    @(negedge clk);
    check("post_hs_busy", busy, 0);
    check("post_hs_cmd_ready", cmd_ready, 1);
    check("post_hs_rd_en", act_rd_en, 0);

    // Reset in cycle 2 of an N=8 job
    @(posedge clk);
    #1;
    send_cmd(8'd8, 8'h40, 8'h48, es);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_act_q.delete();
    exp_wgt_q.delete();
    void'(exp_q.pop_back());
    void'(exp_lat_q.pop_back());
    void'(exp_pe_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_act_rd_en", act_rd_en, 0);
    check("midrst_wgt_rd_en", wgt_rd_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_pe_en", pe_en, 0);
    repeat (15) @(negedge clk);
    check("midrst_no_result", done_cnt, jobs);
    @(posedge clk);
    #1;
    act_mem[8'h50] = 8'd3;
    wgt_mem[8'h60] = 8'd4;
    send_cmd(8'd1, 8'h50, 8'h60, es);
    jobs++; wait_done(jobs);

    repeat (3) @(negedge clk);
    check("queues_drained", exp_q.size() + exp_act_q.size() + exp_wgt_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
